// File: rtl/mdom_wvb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdom_wvb_pkg: header bundle layout, header word constants, states   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mdom_wvb_pkg;

  localparam int HDR_BUNDLE_W = 80;
  localparam int LTC_LSB      = 0;
  localparam int LTC_W        = 48;
  localparam int START_LSB    = 48;
  localparam int STOP_LSB     = 60;
  localparam int ADDR_FLD_W   = 12;
  localparam int TRIG_LSB     = 72;
  localparam int TRIG_W       = 2;
  localparam int CNST_BIT     = 74;
  localparam int PRE_LSB      = 75;
  localparam int PRE_W        = 5;

  localparam logic [3:0] HDR_MAGIC = 4'hE;
  localparam int         HDR_WORDS = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [PRE_W-1:0]      pre_conf;
    logic                  cnst_run;
    logic [TRIG_W-1:0]     trig_src;
    logic [ADDR_FLD_W-1:0] stop_addr;
    logic [ADDR_FLD_W-1:0] start_addr;
    logic [LTC_W-1:0]      evt_ltc;
  } hdr_t;

  function automatic hdr_t unpack_hdr(input logic [HDR_BUNDLE_W-1:0] b);
    hdr_t h;
    h.evt_ltc    = b[LTC_LSB +: LTC_W];
    h.start_addr = b[START_LSB +: ADDR_FLD_W];
    h.stop_addr  = b[STOP_LSB +: ADDR_FLD_W];
    h.trig_src   = b[TRIG_LSB +: TRIG_W];
    h.cnst_run   = b[CNST_BIT];
    h.pre_conf   = b[PRE_LSB +: PRE_W];
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdom_wvb_rd_skid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdom_wvb_rd_skid: small output FIFO carrying data, sof and eof      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mdom_wvb_rd_skid #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_sof_i,
  input  logic              push_eof_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int W     = DATA_W + 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     head;
  logic             pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;
  assign head    = mem_q[rd_q];
  assign count_o = count_q;
  // Head word is gated so an empty FIFO presents all-zero outputs.
  assign data_o  = valid_o ? head[W-1:2] : '0;
  assign sof_o   = valid_o && head[1];
  assign eof_o   = valid_o && head[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= {push_data_i, push_sof_i, push_eof_i};
        wr_q        <= inc_ptr(wr_q);
      end
      if (pop) rd_q <= inc_ptr(rd_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdom_wvb_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdom_wvb_reader: pops one header per event, emits 5 header words    |
// | then start..stop samples from the waveform RAM. Rev 1.0             |
// +--------------------------------------------------------------------+
module mdom_wvb_reader
  import mdom_wvb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int RAM_LAT = 2,
  parameter int SKID_D  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hdr_empty,
  input  logic [79:0]       hdr_data,
  output logic              hdr_rdreq,
  output logic [ADDR_W-1:0] wvb_rd_addr,
  input  logic [DATA_W-1:0] wvb_rd_data,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sof,
  output logic              dout_eof,
  output logic              buf_free,
  output logic [ADDR_W-1:0] buf_free_addr,
  output logic              busy
);

  localparam int CNT_W = $clog2(SKID_D + 1);
  localparam int IFL_W = $clog2(RAM_LAT + 1);

  logic [2:0]         state_q, state_d;
  hdr_t               hdr_q, hdr_d;
  logic [2:0]         widx_q, widx_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d, addr_q;
  logic [RAM_LAT-1:0] vld_q, eof_q;
  logic               hdr_rdreq_q, buf_free_q;
  logic [ADDR_W-1:0]  buf_free_addr_q;

  logic [CNT_W-1:0]   occ;
  logic [IFL_W-1:0]   in_flight;
  logic [ADDR_W-1:0]  start_a, stop_a;
  logic [ADDR_W:0]    nsamp;
  logic [DATA_W-1:0]  hdr_word, push_word;
  logic               push, push_sof, push_eof;
  logic               hdr_push, issue, last, credit_ok;

  assign start_a   = ADDR_W'(hdr_q.start_addr);
  assign stop_a    = ADDR_W'(hdr_q.stop_addr);
  assign nsamp     = {1'b0, stop_a - start_a} + (ADDR_W + 1)'(1);
  assign last      = (rd_ptr_q == stop_a);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LAT; i++) in_flight = in_flight + IFL_W'(vld_q[i]);
  end

  // Every outstanding read owns a FIFO slot, so returning data always fits.
  assign credit_ok   = (int'(occ) + int'(in_flight)) < SKID_D;
  assign issue       = (state_q == ST_DATA) && credit_ok;
  assign hdr_push    = (state_q == ST_HDR) && (int'(occ) < SKID_D);
  assign wvb_rd_addr = issue ? rd_ptr_q : addr_q;

  always_comb begin
    hdr_word = '0;
    case (widx_q)
      3'd0:    hdr_word = DATA_W'({HDR_MAGIC, 1'b0, hdr_q.cnst_run, hdr_q.trig_src,
                                   3'b000, hdr_q.pre_conf});
      3'd1:    hdr_word = DATA_W'(hdr_q.evt_ltc[47:32]);
      3'd2:    hdr_word = DATA_W'(hdr_q.evt_ltc[31:16]);
      3'd3:    hdr_word = DATA_W'(hdr_q.evt_ltc[15:0]);
      default: hdr_word = DATA_W'(nsamp);
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    push_sof  = 1'b0;
    push_eof  = 1'b0;
    if (vld_q[RAM_LAT-1]) begin
      push      = 1'b1;
      push_word = wvb_rd_data;
      push_eof  = eof_q[RAM_LAT-1];
    end else if (hdr_push) begin
      push      = 1'b1;
      push_word = hdr_word;
      push_sof  = (widx_q == 3'd0);
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    widx_d   = widx_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      ST_IDLE: if (en && !hdr_empty) begin
        hdr_d   = unpack_hdr(hdr_data);
        widx_d  = 3'd0;
        state_d = ST_HDR;
      end
      ST_HDR: if (hdr_push) begin
        widx_d = widx_q + 3'd1;
        if (widx_q == 3'(HDR_WORDS - 1)) begin
          rd_ptr_d = start_a;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: if (issue) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (last) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (in_flight == '0 && occ == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      hdr_q           <= '0;
      widx_q          <= '0;
      rd_ptr_q        <= '0;
      addr_q          <= '0;
      vld_q           <= '0;
      eof_q           <= '0;
      hdr_rdreq_q     <= 1'b0;
      buf_free_q      <= 1'b0;
      buf_free_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      widx_q      <= widx_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_q      <= wvb_rd_addr;
      vld_q       <= (vld_q << 1) | RAM_LAT'(issue);
      eof_q       <= (eof_q << 1) | RAM_LAT'(issue && last);
      hdr_rdreq_q <= (state_q == ST_IDLE) && en && !hdr_empty;
      buf_free_q  <= (state_q == ST_DRAIN) && (state_d == ST_DONE);
      if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) buf_free_addr_q <= stop_a;
    end
  end

  assign hdr_rdreq     = hdr_rdreq_q;
  assign buf_free      = buf_free_q;
  assign buf_free_addr = buf_free_addr_q;
  assign busy          = (state_q != ST_IDLE);

  mdom_wvb_rd_skid #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_D),
    .CNT_W  (CNT_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_word),
    .push_sof_i  (push_sof),
    .push_eof_i  (push_eof),
    .ready_i     (dout_ready),
    .data_o      (dout_data),
    .sof_o       (dout_sof),
    .eof_o       (dout_eof),
    .valid_o     (dout_valid),
    .count_o     (occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_mdom_wvb_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mdom_wvb_reader: scoreboard bench for the waveform-buffer reader |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mdom_wvb_reader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int SKID_D = 4;

  logic              clk = 1'b0;
  logic              rst, en, hdr_empty, hdr_rdreq, dout_valid, dout_ready;
  logic              dout_sof, dout_eof, buf_free, busy;
  logic [79:0]       hdr_data;
  logic [ADDR_W-1:0] wvb_rd_addr, buf_free_addr;
  logic [DATA_W-1:0] wvb_rd_data, dout_data, ram_p1, ram_p2;

  always #5 clk = ~clk;

  mdom_wvb_reader u_dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .hdr_empty     (hdr_empty),
    .hdr_data      (hdr_data),
    .hdr_rdreq     (hdr_rdreq),
    .wvb_rd_addr   (wvb_rd_addr),
    .wvb_rd_data   (wvb_rd_data),
    .dout_data     (dout_data),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_sof      (dout_sof),
    .dout_eof      (dout_eof),
    .buf_free      (buf_free),
    .buf_free_addr (buf_free_addr),
    .busy          (busy)
  );

  // Two-cycle RAM with RAM[a] = a.
  always @(posedge clk) begin
    ram_p1 <= DATA_W'(wvb_rd_addr);
    ram_p2 <= ram_p1;
  end
  assign wvb_rd_data = ram_p2;

  // Show-ahead header FIFO.
  logic [79:0] hdr_mem [16];
  int          hdr_wr = 0;
  int          hdr_rd = 0;
  assign hdr_empty = (hdr_wr == hdr_rd);
  assign hdr_data  = hdr_mem[hdr_rd % 16];
  always @(posedge clk) if (hdr_rdreq) hdr_rd <= hdr_rd + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
  } word_t;

  word_t exp_q[$];
  word_t mon_w, stall_w;
  logic  stall_q = 1'b0;
  int    errors = 0, checks = 0;
  int    free_cnt = 0, pop_cnt = 0, eof_cnt = 0, max_occ = 0;
  int    last_free_cyc = 0, last_pop_cyc = 0, widx = 0;
  logic [15:0] cap_w0, cap_w4, cap_eof;
  bit    rnd_mode = 1'b0;

  function automatic logic [79:0] mk_hdr(input logic [47:0] ltc, input logic [11:0] start,
                                         input logic [11:0] stop, input logic [1:0] trig,
                                         input logic cnst, input logic [4:0] pre);
    return {pre, cnst, trig, stop, start, ltc};
  endfunction

  // Expected stream for one popped header.
  task automatic gen_event(input logic [79:0] h);
    logic [11:0] a, start, stop;
    logic [12:0] n;
    start = h[59:48];
    stop  = h[71:60];
    n     = {1'b0, 12'(stop - start)} + 13'd1;
    exp_q.push_back({4'hE, 1'b0, h[74], h[73:72], 3'b000, h[79:75], 1'b1, 1'b0});
    exp_q.push_back({h[47:32], 2'b00});
    exp_q.push_back({h[31:16], 2'b00});
    exp_q.push_back({h[15:0], 2'b00});
    exp_q.push_back({3'b000, n, 2'b00});
    a = start;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back({4'h0, a, 1'b0, (i == int'(n) - 1)});
      a = a + 12'd1;
    end
  endtask

  task automatic enq(input logic [79:0] h);
    hdr_mem[hdr_wr % 16] = h;
    hdr_wr = hdr_wr + 1;
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 48'({hdr_rdreq, wvb_rd_addr, dout_data, dout_valid, dout_sof, dout_eof,
                   buf_free, buf_free_addr, busy}), 48'd0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while ((free_cnt < target || exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (free_cnt < target || exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL wait_done: freed %0d required %0d, pending words %0d", free_cnt, target,
               exp_q.size());
    end
  endtask

  // Random ready driver.
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        if (hdr_rdreq) begin
          pop_cnt++;
          last_pop_cyc = cyc;
          gen_event(hdr_mem[hdr_rd % 16]);
        end
        if (buf_free) begin
          free_cnt++;
          last_free_cyc = cyc;
        end
        if (int'(u_dut.u_skid.count_q) > max_occ) max_occ = int'(u_dut.u_skid.count_q);
        if (stall_q) begin
          checks++;
          if (!dout_valid || {dout_data, dout_sof, dout_eof} != stall_w) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b %0h required v=1 %0h", dout_valid,
                     {dout_data, dout_sof, dout_eof}, stall_w);
          end
        end
        if (dout_valid && dout_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got unexpected word %0h required none", dout_data);
          end else begin
            mon_w = exp_q.pop_front();
            if ({dout_data, dout_sof, dout_eof} != mon_w) begin
              errors++;
              $display("FAIL scoreboard: got %0h sof=%0b eof=%0b required %0h sof=%0b eof=%0b",
                       dout_data, dout_sof, dout_eof, mon_w.data, mon_w.sof, mon_w.eof);
            end
          end
          if (dout_sof) widx = 0;
          if (widx == 0) cap_w0 = dout_data;
          if (widx == 4) cap_w4 = dout_data;
          if (dout_eof) begin
            cap_eof = dout_data;
            eof_cnt++;
          end
          widx++;
        end
        stall_q = dout_valid && !dout_ready;
        stall_w = {dout_data, dout_sof, dout_eof};
      end
    end
  end

  initial begin
    int f0, p0, e0, free1, n;
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b0;

    // 1: simple four-sample event
    en = 1'b1;
    enq(mk_hdr(48'h123456789ABC, 12'h010, 12'h013, 2'b10, 1'b1, 5'h1A));
    wait_done(1, 300);
    chk("t1_w0", 48'(cap_w0), 48'hE61A);
    chk("t1_w4", 48'(cap_w4), 48'h0004);
    chk("t1_eof_data", 48'(cap_eof), 48'h0013);
    chk("t1_free_addr", 48'(buf_free_addr), 48'h013);

    // 2: address wrap
    enq(mk_hdr(48'h0000_0000_0001, 12'hFFE, 12'h001, 2'b01, 1'b0, 5'h03));
    wait_done(2, 300);
    chk("t2_w4", 48'(cap_w4), 48'h0004);
    chk("t2_eof_data", 48'(cap_eof), 48'h0001);
    chk("t2_free_addr", 48'(buf_free_addr), 48'h001);

    // 3: full buffer, 4096 samples
    e0 = eof_cnt;
    enq(mk_hdr(48'hFFFF_0000_FFFF, 12'h100, 12'h0FF, 2'b11, 1'b0, 5'h1F));
    wait_done(3, 20000);
    chk("t3_w4", 48'(cap_w4), 48'h1000);
    chk("t3_eof_count", 48'(eof_cnt - e0), 48'd1);
    chk("t3_free_count", 48'(free_cnt), 48'd3);

    // 4: random backpressure, three queued events
    rnd_mode = 1'b1;
    enq(mk_hdr(48'hA5A5_5A5A_0F0F, 12'h050, 12'h062, 2'b00, 1'b1, 5'h01));
    enq(mk_hdr(48'h0102_0304_0506, 12'hFFA, 12'h003, 2'b01, 1'b0, 5'h10));
    enq(mk_hdr(48'hDEAD_BEEF_CAFE, 12'h777, 12'h777, 2'b10, 1'b1, 5'h00));
    wait_done(6, 4000);
    rnd_mode = 1'b0;
    chk("t4_w4_last", 48'(cap_w4), 48'h0001);
    chk("t4_free_addr", 48'(buf_free_addr), 48'h777);

    // 5: en dropped during event 1 holds back event 2
    en = 1'b0;
    f0 = free_cnt;
    p0 = pop_cnt;
    enq(mk_hdr(48'h1111_2222_3333, 12'h020, 12'h027, 2'b00, 1'b0, 5'h02));
    enq(mk_hdr(48'h4444_5555_6666, 12'h030, 12'h032, 2'b01, 1'b1, 5'h04));
    @(negedge clk);
    en = 1'b1;
    n = 0;
    while (pop_cnt == p0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    wait_done(f0 + 1, 300);
    free1 = last_free_cyc;
    repeat (20) @(negedge clk);
    chk("t5_second_not_popped", 48'(pop_cnt), 48'(p0 + 1));
    en = 1'b1;
    wait_done(f0 + 2, 300);
    chk("t5_pop_after_free", 48'(last_pop_cyc > free1), 48'd1);
    chk("t5_free_addr", 48'(buf_free_addr), 48'h032);

    // 6: reset in the middle of DATA
    f0 = free_cnt;
    enq(mk_hdr(48'h7777_8888_9999, 12'h200, 12'h23F, 2'b11, 1'b0, 5'h05));
    enq(mk_hdr(48'hABCD_EF01_2345, 12'h300, 12'h302, 2'b10, 1'b1, 5'h06));
    n = 0;
    while (wvb_rd_addr != 12'h208 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_data", 48'(wvb_rd_addr), 48'h208);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 chk_zero("t6_reset_zero");
    repeat (3) @(negedge clk);
    chk_zero("t6_reset_hold");
    rst = 1'b0;
    chk("t6_no_free", 48'(free_cnt), 48'(f0));
    wait_done(f0 + 1, 300);
    chk("t6_free_addr", 48'(buf_free_addr), 48'h302);
    chk("t6_w4", 48'(cap_w4), 48'h0003);

    chk("exp_queue_empty", 48'(exp_q.size()), 48'd0);
    chk("skid_occ_bound", 48'(max_occ <= SKID_D), 48'd1);
    chk("total_free", 48'(free_cnt), 48'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
